// File: rtl/sap_accumulator_alu_if.sv
// Bus/handshake bundle for the SAP accumulator ALU.
// The master side drives the bus and control strobes; the slave side is the accumulator block.
interface sap_accumulator_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_in;
    logic             load_a;
    logic             load_b;
    logic             enable_output;
    logic             op_valid;
    logic [2:0]       op;

    logic             op_ready;
    logic             done;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output bus_in, load_a, load_b, enable_output, op_valid, op,
        input  op_ready, done, bus_out, bus_oe, reg_a, reg_b,
        input  flag_c, flag_z, flag_n, flag_v
    );

    modport slave (
        input  bus_in, load_a, load_b, enable_output, op_valid, op,
        output op_ready, done, bus_out, bus_oe, reg_a, reg_b,
        output flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/sap_accumulator_alu.sv
// SAP-style accumulator with operand register, single-cycle ALU ops and an
// optional multi-cycle shift-add multiplier; product lands in A (low) and B (high).
module sap_accumulator_alu #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sap_accumulator_alu_if.slave io
);
    localparam int               MSB       = WIDTH - 1;
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic               v_q, v_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               accept;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_write;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_prod;

    assign accept = io.op_valid && (state_q == S_IDLE);

    // Single-cycle datapath; alu_write is low for the multiply opcode.
    always_comb begin
        alu_res   = a_q;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_write = 1'b1;
        add_full  = {1'b0, a_q} + {1'b0, b_q};
        sub_full  = {1'b0, a_q} - {1'b0, b_q};
        case (op_e'(io.op))
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (add_full[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (sub_full[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_MUL: alu_write = 1'b0;
        endcase
    end

    // One shift-add step: the multiplier sits in the low half of prod_q and is
    // consumed LSB-first while partial sums accumulate into the high half.
    always_comb begin
        step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step_prod = {step_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    if (alu_write) begin
                        a_d = alu_res;
                        c_d = alu_c;
                        z_d = (alu_res == '0);
                        n_d = alu_res[MSB];
                        v_d = alu_v;
                    end else if (MUL_EN) begin
                        state_d = S_MUL;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                        mcand_d = a_q;
                        prod_d  = {{WIDTH{1'b0}}, b_q};
                    end
                end else begin
                    if (io.load_a) a_d = io.bus_in;
                    if (io.load_b) b_d = io.bus_in;
                end
            end
            S_MUL: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    a_d     = step_prod[WIDTH-1:0];
                    b_d     = step_prod[2*WIDTH-1:WIDTH];
                    c_d     = |step_prod[2*WIDTH-1:WIDTH];
                    z_d     = (step_prod == '0);
                    n_d     = step_prod[MSB];
                    v_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    wire [WIDTH-1:0] a_gated;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus_out
        assign a_gated[gi] = a_q[gi] & io.enable_output;
    end

    assign io.bus_out  = a_gated;
    assign io.bus_oe   = io.enable_output;
    assign io.op_ready = (state_q == S_IDLE);
    assign io.done     = done_q;
    assign io.reg_a    = a_q;
    assign io.reg_b    = b_q;
    assign io.flag_c   = c_q;
    assign io.flag_z   = z_q;
    assign io.flag_n   = n_q;
    assign io.flag_v   = v_q;
endmodule
